temp_sensor_reader: RTL and testbench

- Serial-interface master for the board temperature sensor: 16-bit read-only frame, CS/SCK/SO.
- Polls the sensor periodically and delivers a signed 13-bit temperature word with a one-cycle valid strobe.
- Produces a hysteretic over-temperature flag and a sensor-fault flag.
- Sits directly downstream of the sensor pins and upstream of the power-enable/crash logic inside CPLD_CONTROL.

---
 rtl/temp_sensor_reader_pkg.sv | 25 ++
 rtl/temp_sensor_reader_sck.sv | 72 +++++++
 rtl/temp_sensor_reader.sv | 188 ++++++++++++++++++
 tb/tb_temp_sensor_reader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/temp_sensor_reader_pkg.sv
// temp_sensor_reader_pkg
//   Shared definitions for the board temperature sensor reader and the
//   CPLD_CONTROL logic that consumes its outputs.
//   - tsr_state_e : one-hot reader FSM state encoding (5 bits)
//   - frame layout: leading-zero field [15:13], temperature field [12:0]
//   - conversion  : 16 codes per degree C (LSB = 0.0625 C)
package temp_sensor_reader_pkg;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_CS_SETUP = 5'b00010,
    ST_SHIFT    = 5'b00100,
    ST_CS_HOLD  = 5'b01000,
    ST_UPDATE   = 5'b10000
  } tsr_state_e;

  localparam int unsigned TSR_FRAME_WL       = 16;
  localparam int unsigned TSR_DATA_WL        = 13;
  localparam int unsigned TSR_LZ_MSB         = 15;
  localparam int unsigned TSR_LZ_LSB         = 13;
  localparam int unsigned TSR_DATA_MSB       = 12;
  localparam int unsigned TSR_DATA_LSB       = 0;
  localparam int unsigned TSR_CODES_PER_DEGC = 16;

endpackage

// File: rtl/temp_sensor_reader_sck.sv
// temp_sck_gen
//   SCK divider for the temperature sensor interface. While enabled, counts
//   C_SCK_DIV clocks per half-period; toggles the registered SCK level at the
//   end of a half-period when toggle_i is set. SCK idles high when disabled.
//   Ports:
//     clk_i        system clock
//     rst_ni       synchronous active-low reset
//     en_i         divider running (CS_SETUP / SHIFT / CS_HOLD)
//     toggle_i     allow SCK to toggle at the end of the current half-period
//     sck_o        registered SCK level
//     rise_o       high in the first cycle in which sck_o is high after a rise
//     fall_o       high in the first cycle in which sck_o is low after a fall
//     half_done_o  last cycle of the current half-period
module temp_sck_gen #(
  parameter int unsigned C_SCK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic toggle_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o,
  output logic half_done_o
);

  localparam int unsigned CNT_W = $clog2(C_SCK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             half_done;

  assign half_done = en_i && (cnt_q == CNT_W'(C_SCK_DIV - 1));

  always_comb begin
    cnt_d  = '0;
    sck_d  = 1'b1;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (en_i) begin
      cnt_d = half_done ? '0 : cnt_q + 1'b1;
      sck_d = sck_q;
      if (half_done && toggle_i) begin
        sck_d  = ~sck_q;
        rise_d = ~sck_q;
        fall_d = sck_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sck_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sck_q  <= sck_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sck_o       = sck_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign half_done_o = half_done;

endmodule

// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader
//   Periodically reads a 16-bit frame from the board temperature sensor
//   (CS/SCK/SO, MSB first), publishes the signed 13-bit temperature with a
//   one-cycle valid strobe, and keeps a hysteretic over-temperature flag and
//   a malformed-frame fault flag. All outputs are registered.
//   Ports:
//     CLK_IN               system clock
//     RESET_N_IN           synchronous active-low reset
//     Temp_sensor_SO_IN    sensor serial data
//     Temp_sensor_CS_OUT   chip select, active low
//     Temp_sensor_SCK_OUT  serial clock, idles high
//     Temp_Data_OUT        last good temperature (two's complement)
//     Temp_Valid_OUT       one-cycle pulse when Temp_Data_OUT updates
//     Over_Temp_OUT        over-temperature flag (set out of reset)
//     Sensor_Fault_OUT     last frame had non-zero leading bits
module temp_sensor_reader
  import temp_sensor_reader_pkg::*;
#(
  parameter bit          C_SIMULATION          = 1'b0,
  parameter int unsigned C_TEMP_SENSOR_PO_WL   = TSR_FRAME_WL,
  parameter int unsigned C_TEMP_SENSOR_DATA_WL = TSR_DATA_WL,
  parameter int unsigned C_SCK_DIV             = 4,
  parameter int unsigned C_POLL_PERIOD         = 40000,
  parameter int          C_MAX_TEMP_CODE       = 640,
  parameter int          C_HYST_CODE           = 64
) (
  input  logic                             CLK_IN,
  input  logic                             RESET_N_IN,
  input  logic                             Temp_sensor_SO_IN,
  output logic                             Temp_sensor_CS_OUT,
  output logic                             Temp_sensor_SCK_OUT,
  output logic [C_TEMP_SENSOR_DATA_WL-1:0] Temp_Data_OUT,
  output logic                             Temp_Valid_OUT,
  output logic                             Over_Temp_OUT,
  output logic                             Sensor_Fault_OUT
);

  localparam int unsigned PO     = C_TEMP_SENSOR_PO_WL;
  localparam int unsigned DW     = C_TEMP_SENSOR_DATA_WL;
  localparam int unsigned EW     = DW + 1;
  localparam int unsigned PERIOD = C_SIMULATION ? 64 : C_POLL_PERIOD;
  localparam int unsigned PCNT_W = $clog2(PERIOD);
  localparam int unsigned BCNT_W = $clog2(PO + 1);

  localparam logic signed [EW-1:0] SET_THR = EW'(C_MAX_TEMP_CODE);
  localparam logic signed [EW-1:0] CLR_THR = EW'(C_MAX_TEMP_CODE - C_HYST_CODE);

  tsr_state_e        state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [PO-1:0]     shift_q, shift_d;
  logic              cs_q, cs_d;
  logic [DW-1:0]     data_q, data_d;
  logic              valid_q, valid_d;
  logic              over_q, over_d;
  logic              fault_q, fault_d;
  logic              first_q, first_d;

  logic              sck_en, sck_toggle, sck, sck_rise, sck_fall, half_done;
  logic              last_bit;
  logic              frame_ok;
  logic signed [EW-1:0] temp_ext;

  assign sck_en   = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                    (state_q == ST_CS_HOLD);
  assign last_bit = (bcnt_q == BCNT_W'(PO));
  // SCK drops on entry to SHIFT and keeps toggling until the high half of
  // the final bit has run its full length; it then stays high into CS_HOLD.
  assign sck_toggle = (state_q == ST_CS_SETUP) ||
                      ((state_q == ST_SHIFT) && !(sck && last_bit));

  temp_sck_gen #(
    .C_SCK_DIV (C_SCK_DIV)
  ) u_sck (
    .clk_i       (CLK_IN),
    .rst_ni      (RESET_N_IN),
    .en_i        (sck_en),
    .toggle_i    (sck_toggle),
    .sck_o       (sck),
    .rise_o      (sck_rise),
    .fall_o      (sck_fall),
    .half_done_o (half_done)
  );

  assign frame_ok = (shift_q[PO-1:DW] == '0);
  assign temp_ext = {shift_q[DW-1], shift_q[DW-1:0]};

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    over_d  = over_q;
    fault_d = fault_q;
    first_d = first_q;

    case (state_q)
      ST_IDLE: begin
        if (pcnt_q == PCNT_W'(PERIOD - 1)) begin
          pcnt_d  = '0;
          state_d = ST_CS_SETUP;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      ST_CS_SETUP: begin
        bcnt_d = '0;
        if (half_done) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sck_rise && !sck_fall) begin
          shift_d = {shift_q[PO-2:0], Temp_sensor_SO_IN};
          bcnt_d  = bcnt_q + 1'b1;
        end
        if (half_done && sck && last_bit) state_d = ST_CS_HOLD;
      end
      ST_CS_HOLD: begin
        // Results are registered on the way into UPDATE so that the valid
        // strobe and new flags are visible during the UPDATE cycle itself.
        if (half_done) begin
          state_d = ST_UPDATE;
          if (frame_ok) begin
            data_d  = shift_q[DW-1:0];
            valid_d = 1'b1;
            fault_d = 1'b0;
            first_d = 1'b0;
            if (first_q) begin
              over_d = (temp_ext > SET_THR);
            end else if (temp_ext > SET_THR) begin
              over_d = 1'b1;
            end else if (temp_ext < CLR_THR) begin
              over_d = 1'b0;
            end
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
      end
    endcase

    cs_d = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) ||
             (state_d == ST_CS_HOLD));
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_N_IN) begin
      state_q <= ST_IDLE;
      pcnt_q  <= PCNT_W'(PERIOD - 1);
      bcnt_q  <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b1;
      fault_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      cs_q    <= cs_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      over_q  <= over_d;
      fault_q <= fault_d;
      first_q <= first_d;
    end
  end

  assign Temp_sensor_CS_OUT  = cs_q;
  assign Temp_sensor_SCK_OUT = sck;
  assign Temp_Data_OUT       = data_q;
  assign Temp_Valid_OUT      = valid_q;
  assign Over_Temp_OUT       = over_q;
  assign Sensor_Fault_OUT    = fault_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb_temp_sensor_reader
//   Directed bench for temp_sensor_reader in simulation mode (64-clock poll,
//   SCK_DIV = 4). A behavioural sensor shifts out the requested frame MSB
//   first, changing SO after each SCK falling edge.
module tb_temp_sensor_reader;

  localparam int unsigned DIV       = 4;
  localparam int          CS_LOW    = 2 * DIV * (16 + 1);      // 136
  localparam int          FRAME_LEN = 2 * DIV * (16 + 1) + 1;  // 137
  localparam int          SPACING   = 64 + FRAME_LEN;          // 201

  logic        clk;
  logic        rst_n;
  logic        so;
  logic        cs;
  logic        sck;
  logic [12:0] tdata;
  logic        tvalid;
  logic        over;
  logic        fault;

  int n_checks;
  int n_errors;
  int cyc;
  int valid_cnt;
  int rises;
  int frame_no;
  int last_fall;
  int prev_fall;
  logic [15:0] tx_frame;

  temp_sensor_reader #(
    .C_SIMULATION (1'b1),
    .C_SCK_DIV    (DIV)
  ) dut (
    .CLK_IN              (clk),
    .RESET_N_IN          (rst_n),
    .Temp_sensor_SO_IN   (so),
    .Temp_sensor_CS_OUT  (cs),
    .Temp_sensor_SCK_OUT (sck),
    .Temp_Data_OUT       (tdata),
    .Temp_Valid_OUT      (tvalid),
    .Over_Temp_OUT       (over),
    .Sensor_Fault_OUT    (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tvalid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  // Behavioural sensor.
  initial begin
    logic [15:0] cur;
    logic        prev_cs;
    logic        prev_sck;
    cur      = '0;
    prev_cs  = 1'b1;
    prev_sck = 1'b1;
    so       = 1'b0;
    rises    = 0;
    forever begin
      @(cs or sck);
      if (prev_cs === 1'b1 && cs === 1'b0) begin
        cur   = tx_frame;
        rises = 0;
        so    = cur[15];
      end else if (cs === 1'b0 && prev_sck === 1'b1 && sck === 1'b0) begin
        if (rises > 0 && rises < 16) so = cur[15 - rises];
      end else if (cs === 1'b0 && prev_sck === 1'b0 && sck === 1'b1) begin
        rises = rises + 1;
      end
      prev_cs  = cs;
      prev_sck = sck;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic [15:0] f, input logic exp_v, input logic [12:0] exp_d,
                          input logic exp_ot, input logic exp_f, input bit chk_sp);
    int n;
    bit ok;
    int v0;
    frame_no++;
    tx_frame = f;
    v0 = valid_cnt;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (cs === 1'b0) ok = 1'b1;
    end
    check($sformatf("f%0d_cs_fall", frame_no), ok, 1);
    if (!ok) return;
    prev_fall = last_fall;
    last_fall = cyc;
    if (chk_sp) check($sformatf("f%0d_spacing", frame_no), last_fall - prev_fall, SPACING);
    n  = 1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cs === 1'b1) ok = 1'b1;
      else n++;
    end
    check($sformatf("f%0d_cs_rise", frame_no), ok, 1);
    check($sformatf("f%0d_cs_low", frame_no), n, CS_LOW);
    check($sformatf("f%0d_sck_rises", frame_no), rises, 16);
    check($sformatf("f%0d_valid", frame_no), tvalid, exp_v);
    check($sformatf("f%0d_data", frame_no), tdata, exp_d);
    check($sformatf("f%0d_over", frame_no), over, exp_ot);
    check($sformatf("f%0d_fault", frame_no), fault, exp_f);
    @(negedge clk);
    check($sformatf("f%0d_valid_end", frame_no), tvalid, 1'b0);
    check($sformatf("f%0d_valid_cnt", frame_no), valid_cnt - v0, exp_v);
  endtask

  initial begin
    int v0;
    int rel_cyc;
    bit ok;
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    valid_cnt = 0;
    frame_no  = 0;
    last_fall = 0;
    prev_fall = 0;
    tx_frame  = 16'h0190;
    rst_n     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1'b1);
    check("rst_sck", sck, 1'b1);
    check("rst_data", tdata, 13'h0);
    check("rst_valid", tvalid, 1'b0);
    check("rst_over", over, 1'b1);
    check("rst_fault", fault, 1'b0);
    rst_n   = 1'b1;
    rel_cyc = cyc;

    // 25.0 C: Over_Temp 1 -> 0 on the first good frame.
    do_frame(16'h0190, 1'b1, 13'h0190, 1'b0, 1'b0, 1'b0);
    check("first_frame_start", last_fall - rel_cyc, 1);
    // 45.0 C sets the flag.
    do_frame(16'h02D0, 1'b1, 13'h02D0, 1'b1, 1'b0, 1'b1);
    // Malformed frame: data and flag held, fault raised, no strobe.
    do_frame(16'hE190, 1'b0, 13'h02D0, 1'b1, 1'b1, 1'b1);
    // 39.0 and 37.5 C sit in the hysteresis band; 35.0 C clears.
    do_frame(16'h0270, 1'b1, 13'h0270, 1'b1, 1'b0, 1'b1);
    do_frame(16'h0258, 1'b1, 13'h0258, 1'b1, 1'b0, 1'b1);
    do_frame(16'h0230, 1'b1, 13'h0230, 1'b0, 1'b0, 1'b1);
    // -10.0 C must compare as negative.
    do_frame(16'h1F60, 1'b1, 13'h1F60, 1'b0, 1'b0, 1'b1);
    // Good, bad, good: fault set then cleared.
    do_frame(16'h0190, 1'b1, 13'h0190, 1'b0, 1'b0, 1'b1);
    do_frame(16'hE190, 1'b0, 13'h0190, 1'b0, 1'b1, 1'b1);
    do_frame(16'h0200, 1'b1, 13'h0200, 1'b0, 1'b0, 1'b1);

    // Reset during bit 7 of SHIFT.
    tx_frame = 16'h0300;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (cs === 1'b0 && rises == 7) ok = 1'b1;
    end
    check("midrst_reach_bit7", ok, 1);
    v0    = valid_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs", cs, 1'b1);
    check("midrst_sck", sck, 1'b1);
    check("midrst_over", over, 1'b1);
    check("midrst_valid", tvalid, 1'b0);
    check("midrst_data", tdata, 13'h0);
    check("midrst_fault", fault, 1'b0);
    tx_frame = 16'h0250;
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    // 37.0 C as the first good frame after reset: plain threshold, clears.
    do_frame(16'h0250, 1'b1, 13'h0250, 1'b0, 1'b0, 1'b0);
    check("midrst_restart", last_fall - rel_cyc, 1);
    check("midrst_valid_total", valid_cnt - v0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
